// File: rtl/counting.sv
// Detects a 1+ 2+ 3+ run on a 2-bit symbol stream sampled every clock edge.
// Optional saturating match counter is enabled by defining COUNTING_MATCH_CNT_EN.
module counting #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       num,
  output logic             ans
`ifdef COUNTING_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] S1   = 2'd1;
  localparam logic [1:0] S2   = 2'd2;
  localparam logic [1:0] S3   = 2'd3;

  logic [1:0] state_q, state_d;
  logic       ans_q;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: state_d = (num == 2'd1) ? S1 : IDLE;
      S1: begin
        case (num)
          2'd1:    state_d = S1;
          2'd2:    state_d = S2;
          default: state_d = IDLE;
        endcase
      end
      S2: begin
        case (num)
          2'd1:    state_d = S1;
          2'd2:    state_d = S2;
          2'd3:    state_d = S3;
          default: state_d = IDLE;
        endcase
      end
      S3: begin
        case (num)
          2'd1:    state_d = S1;
          2'd3:    state_d = S3;
          default: state_d = IDLE;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ans_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // ans_q tracks state_q == S3 exactly, but comes straight from a flop.
      ans_q   <= (state_d == S3);
    end
  end

  assign ans = ans_q;

`ifdef COUNTING_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  assign hit = (state_q == S2) && (num == 2'd3);

  always_comb begin
    cnt_d = cnt_q;
    if (hit && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_counting.sv
// Directed bench for counting: a CNT_W=8 instance and a CNT_W=2 instance share stimulus.
// Match-count checks are compiled in only when COUNTING_MATCH_CNT_EN is defined.
module tb_counting;

  logic       clk;
  logic       rst_n;
  logic [1:0] num;
  logic       ans;
  logic       ans_sat;
`ifdef COUNTING_MATCH_CNT_EN
  logic [7:0] match_cnt;
  logic [1:0] cnt_sat;
`endif

  int n_vec;
  int n_err;

  counting #(.CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .num   (num),
    .ans   (ans)
`ifdef COUNTING_MATCH_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  counting #(.CNT_W(2)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .num   (num),
    .ans   (ans_sat)
`ifdef COUNTING_MATCH_CNT_EN
    ,
    .match_cnt (cnt_sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset with a given symbol on num; inputs change 1 time unit after the edge.
  task automatic apply_reset(input logic [1:0] n);
    rst_n = 1'b0;
    num   = n;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [1:0] nv [3] = '{2'd1, 2'd2, 2'd3};
    rst_n = 1'b0;
    num   = 2'd3;
    @(posedge clk);
    #1;
    n_vec++;
    if (ans !== 1'b0) begin n_err++; $display("FAIL reset_ans got=%b want=0", ans); end
`ifdef COUNTING_MATCH_CNT_EN
    n_vec++;
    if (match_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt got=%0d want=0", match_cnt); end
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      num = nv[i];
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (ans !== 1'b1) begin n_err++; $display("FAIL reset_pre_s3 got=%b want=1", ans); end
    // Reset while sitting in S3 with num=1 must win over the S3->S1 arc.
    rst_n = 1'b0;
    num   = 2'd1;
    @(posedge clk);
    #1;
    n_vec++;
    if (ans !== 1'b0) begin n_err++; $display("FAIL reset_in_s3 got=%b want=0", ans); end
`ifdef COUNTING_MATCH_CNT_EN
    n_vec++;
    if (match_cnt !== 8'd0) begin n_err++; $display("FAIL reset_in_s3_cnt got=%0d want=0", match_cnt); end
`endif
    rst_n = 1'b1;
    num   = 2'd2;
    @(posedge clk);
    #1;
    num = 2'd3;
    @(posedge clk);
    #1;
    n_vec++;
    if (ans !== 1'b0) begin n_err++; $display("FAIL reset_release got=%b want=0", ans); end
  endtask

  task automatic test_hold_ones;
    apply_reset(2'd0);
    num = 2'd1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (ans !== 1'b0) begin n_err++; $display("FAIL hold_ones[%0d] got=%b want=0", i, ans); end
    end
`ifdef COUNTING_MATCH_CNT_EN
    n_vec++;
    if (match_cnt !== 8'd0) begin n_err++; $display("FAIL hold_ones_cnt got=%0d want=0", match_cnt); end
`endif
  endtask

  task automatic test_single_match;
    logic [1:0] nv [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    logic       ev [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    apply_reset(2'd0);
    for (int i = 0; i < 5; i++) begin
      num = nv[i];
      @(posedge clk);
      #1;
      n_vec++;
      if (ans !== ev[i]) begin n_err++; $display("FAIL single[%0d] got=%b want=%b", i, ans, ev[i]); end
    end
`ifdef COUNTING_MATCH_CNT_EN
    n_vec++;
    if (match_cnt !== 8'd1) begin n_err++; $display("FAIL single_cnt got=%0d want=1", match_cnt); end
`endif
  endtask

  task automatic test_overlap;
    logic [1:0] nv [9] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    logic       ev [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset(2'd1);
    for (int i = 0; i < 9; i++) begin
      num = nv[i];
      @(posedge clk);
      #1;
      n_vec++;
      if (ans !== ev[i]) begin n_err++; $display("FAIL overlap[%0d] got=%b want=%b", i, ans, ev[i]); end
    end
`ifdef COUNTING_MATCH_CNT_EN
    n_vec++;
    if (match_cnt !== 8'd2) begin n_err++; $display("FAIL overlap_cnt got=%0d want=2", match_cnt); end
`endif
  endtask

  task automatic test_reject;
    logic [1:0] nv [6] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
    apply_reset(2'd2);
    for (int i = 0; i < 6; i++) begin
      num = nv[i];
      @(posedge clk);
      #1;
      n_vec++;
      if (ans !== 1'b0) begin n_err++; $display("FAIL reject[%0d] got=%b want=0", i, ans); end
    end
`ifdef COUNTING_MATCH_CNT_EN
    n_vec++;
    if (match_cnt !== 8'd0) begin n_err++; $display("FAIL reject_cnt got=%0d want=0", match_cnt); end
`endif
  endtask

  task automatic test_reset_mid;
    apply_reset(2'd0);
    num = 2'd1;
    @(posedge clk);
    #1;
    num = 2'd2;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    num   = 2'd3;
    @(posedge clk);
    #1;
    n_vec++;
    if (ans !== 1'b0) begin n_err++; $display("FAIL reset_mid_s2 got=%b want=0", ans); end
    rst_n = 1'b1;
    num   = 2'd3;
    @(posedge clk);
    #1;
    n_vec++;
    if (ans !== 1'b0) begin n_err++; $display("FAIL reset_mid_after got=%b want=0", ans); end
`ifdef COUNTING_MATCH_CNT_EN
    n_vec++;
    if (match_cnt !== 8'd0) begin n_err++; $display("FAIL reset_mid_cnt got=%0d want=0", match_cnt); end
`endif
  endtask

  task automatic test_transitions;
    logic [1:0] nv [20] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd0,
                            2'd2, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3};
    logic       ev [20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset(2'd3);
    for (int i = 0; i < 20; i++) begin
      num = nv[i];
      @(posedge clk);
      #1;
      n_vec++;
      if (ans !== ev[i]) begin n_err++; $display("FAIL arcs[%0d] num=%0d got=%b want=%b", i, nv[i], ans, ev[i]); end
    end
`ifdef COUNTING_MATCH_CNT_EN
    n_vec++;
    if (match_cnt !== 8'd2) begin n_err++; $display("FAIL arcs_cnt got=%0d want=2", match_cnt); end
`endif
  endtask

  task automatic test_saturate;
    logic       ev  [3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0] exp_sat;
    apply_reset(2'd0);
    for (int m = 0; m < 5; m++) begin
      for (int k = 0; k < 3; k++) begin
        num = 2'(k + 1);
        @(posedge clk);
        #1;
        n_vec++;
        if (ans_sat !== ev[k]) begin n_err++; $display("FAIL sat_ans[%0d.%0d] got=%b want=%b", m, k, ans_sat, ev[k]); end
      end
      exp_sat = (m >= 2) ? 2'd3 : 2'(m + 1);
`ifdef COUNTING_MATCH_CNT_EN
      n_vec++;
      if (cnt_sat !== exp_sat) begin n_err++; $display("FAIL sat_cnt[%0d] got=%0d want=%0d", m, cnt_sat, exp_sat); end
`endif
    end
`ifdef COUNTING_MATCH_CNT_EN
    n_vec++;
    if (match_cnt !== 8'd5) begin n_err++; $display("FAIL sat_wide_cnt got=%0d want=5", match_cnt); end
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    num   = 2'd0;
    @(negedge clk);
    test_reset();
    test_hold_ones();
    test_single_match();
    test_overlap();
    test_reject();
    test_reset_mid();
    test_transitions();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counting.md
COUNTING -- requirements
Module: counting

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, giving the width of the match counter (legal range 1..16).
REQ-002 The module SHALL have input port clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have input port rst_n, 1 bit, a synchronous active-low reset sampled on the rising edge of clk.
REQ-004 The module SHALL have input port num, 2 bits, the symbol sampled every rising edge of clk (values 0..3).
REQ-005 The module SHALL have output port ans, 1 bit, registered, asserted when the sampled symbol history ends in a 1+ 2+ 3+ run.
REQ-006 The module SHALL have output port match_cnt, CNT_W bits, registered, counting completed matches; it exists only under COUNTING_MATCH_CNT_EN.

Function
REQ-007 The module SHALL detect the pattern: one or more 1s, then one or more 2s, then one or more 3s, on consecutive sampled symbols.
REQ-008 The FSM SHALL have states IDLE, S1 (1+ seen), S2 (1+2+ seen) and S3 (1+2+3+ seen).
REQ-009 From IDLE, num=1 SHALL go to S1, and any other value SHALL stay in IDLE.
REQ-010 From S1, num=1 SHALL stay in S1, num=2 SHALL go to S2, and num=0 or 3 SHALL go to IDLE.
REQ-011 From S2, num=2 SHALL stay in S2, num=3 SHALL go to S3, num=1 SHALL go to S1, and num=0 SHALL go to IDLE.
REQ-012 From S3, num=3 SHALL stay in S3, num=1 SHALL go to S1, and num=0 or 2 SHALL go to IDLE.
REQ-013 ans SHALL equal (state==S3), taken from the registered state with no combinational path from num.
REQ-014 Latency SHALL be as follows: the edge that samples the first qualifying 3 moves the FSM to S3, and ans is 1 from that edge until the edge that samples a non-3.
REQ-015 A 1 sampled in S3 or S2 SHALL restart matching in S1 (overlapping restart) without passing through IDLE.
REQ-016 match_cnt SHALL increment by 1 on each S2->S3 transition only.
REQ-017 match_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 No handshake SHALL exist: every clock edge consumes one symbol.

Reset
REQ-019 With rst_n=0 at a rising edge, the state SHALL become IDLE, ans SHALL become 0, and match_cnt SHALL become 0, regardless of num.
REQ-020 Reset SHALL take priority over all transitions, including when asserted mid-pattern (for example in S2 while num=3).
REQ-021 On the first edge with rst_n=1, the sampled num SHALL be processed from IDLE.
REQ-022 Before the first reset, outputs SHALL be undefined; the bench shall apply reset first.

Configuration
REQ-023 With macro COUNTING_MATCH_CNT_EN defined, the module SHALL include the match_cnt port, its register and its saturation logic.
REQ-024 With COUNTING_MATCH_CNT_EN undefined, match_cnt SHALL be absent from the port list and logic, and ans behaviour SHALL be identical.

Verification
REQ-025 Scenario 1: reset, then num=1 held for 20 cycles -> ans=0 throughout, match_cnt=0.
REQ-026 Scenario 2: reset, then num = 1,2,3,3,0 -> ans=1 after the first 3 edge and after the second 3 edge, then 0 after the 0; match_cnt=1.
REQ-027 Scenario 3: reset, then num = 1,1,2,2,2,3,1,2,3 -> ans pulses high twice (after each 3); match_cnt=2.
REQ-028 Scenario 4: reset, then num = 1,3,2,3 and separately 2,3 -> ans stays 0 (a 2 without a prior 1 and a 3 directly after a 1 are both rejected).
REQ-029 Scenario 5: num = 1,2 then rst_n=0 on the edge where num=3 -> ans=0; a following 3 with rst_n=1 -> ans=0.
REQ-030 Scenario 6: CNT_W=2 and five matches -> match_cnt=3 (saturated); also build without the macro and confirm ans matches scenarios 1-5.
